block_state_arbiter: RTL and testbench

// - Sequences all accesses to the block_state row store (circular 13-bit line shift register, NUM_ROWS deep).
// - Requesters: blocks_painter (display-time rotate/write) and the SPI host path (spi_ctrl write/shift).
// - Also owns frame re-alignment (head back to row 0) and level fill. Sits between both requesters and block_state.

---
 rtl/breakout_pkg.sv | 13 +
 rtl/bsa_spi_buffer.sv | 51 +++++
 rtl/block_state_arbiter.sv | 146 ++++++++++++++
 tb/tb_block_state_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared definitions for the block_state row-store control path.
package breakout_pkg;

  localparam int LINE_W       = 13;
  localparam int NUM_ROWS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    FILL  = 2'd2
  } bsa_state_e;

endpackage

// File: rtl/bsa_spi_buffer.sv
// One-entry holding register for SPI host requests to the row store.
module bsa_spi_buffer
  import breakout_pkg::*;
(
  input  logic              clk,
  input  logic              nRst,
  input  logic              valid_i,
  input  logic              write_i,
  input  logic              shift_i,
  input  logic [LINE_W-1:0] line_i,
  output logic              ready_o,
  input  logic              pop_i,
  output logic              full_o,
  output logic              write_o,
  output logic              shift_o,
  output logic [LINE_W-1:0] line_o
);

  logic              full_q;
  logic              write_q;
  logic              shift_q;
  logic [LINE_W-1:0] line_q;
  logic              push;

  assign ready_o = !full_q;
  // A request that neither writes nor shifts is consumed without occupying the slot.
  assign push    = valid_i && !full_q && (write_i || shift_i);

  assign full_o  = full_q;
  assign write_o = write_q;
  assign shift_o = shift_q;
  assign line_o  = line_q;

  // Capture on handshake, release when the arbiter issues the held request.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      full_q  <= 1'b0;
      write_q <= 1'b0;
      shift_q <= 1'b0;
      line_q  <= '0;
    end else if (push) begin
      full_q  <= 1'b1;
      write_q <= write_i;
      shift_q <= shift_i;
      line_q  <= line_i;
    end else if (pop_i) begin
      full_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/block_state_arbiter.sv
// Arbitrates painter, frame re-alignment, level fill and SPI access to the
// circular block_state row store, and tracks which row sits at the head.
module block_state_arbiter
  import breakout_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        frame_pulse,
  input  logic                        vblank,
  input  logic                        pnt_next,
  input  logic                        pnt_write,
  input  logic [LINE_W-1:0]           pnt_line,
  input  logic                        spi_valid,
  output logic                        spi_ready,
  input  logic                        spi_write,
  input  logic                        spi_shift,
  input  logic [LINE_W-1:0]           spi_line,
  input  logic                        fill_req,
  input  logic [LINE_W-1:0]           fill_pattern,
  output logic                        fill_busy,
  output logic                        next_line,
  output logic                        write_line,
  output logic [LINE_W-1:0]           new_line,
  output logic [$clog2(NUM_ROWS)-1:0] head_idx,
  output logic                        conflict
);

  localparam int               IDX_W    = $clog2(NUM_ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);

  bsa_state_e        state_q;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  row_q;
  logic              fill_lat_q;
  logic [LINE_W-1:0] fill_pat_q;
  logic              conflict_q;

  logic              pnt_req;
  logic              fill_issue;
  logic              spi_pop;
  logic              buf_full, buf_write, buf_shift;
  logic [LINE_W-1:0] buf_line;

  bsa_spi_buffer u_spi_buf (
    .clk     (clk),
    .nRst    (nRst),
    .valid_i (spi_valid),
    .write_i (spi_write),
    .shift_i (spi_shift),
    .line_i  (spi_line),
    .ready_o (spi_ready),
    .pop_i   (spi_pop),
    .full_o  (buf_full),
    .write_o (buf_write),
    .shift_o (buf_shift),
    .line_o  (buf_line)
  );

  assign pnt_req   = pnt_next || pnt_write;
  assign fill_busy = fill_lat_q || (state_q == FILL);
  assign head_idx  = head_q;
  assign conflict  = conflict_q;
  assign head_d    = !next_line           ? head_q :
                     (head_q == LAST_ROW) ? '0     : head_q + IDX_W'(1);

  // Per-cycle grant: painter, then align, then fill, then a held SPI request.
  always_comb begin
    next_line  = 1'b0;
    write_line = 1'b0;
    new_line   = '0;
    fill_issue = 1'b0;
    spi_pop    = 1'b0;
    if (pnt_req) begin
      next_line  = pnt_next;
      write_line = pnt_write;
      new_line   = pnt_line;
    end else if (state_q == ALIGN) begin
      next_line  = (head_q != '0);
    end else if (state_q == FILL) begin
      next_line  = 1'b1;
      write_line = 1'b1;
      new_line   = fill_pat_q;
      fill_issue = 1'b1;
    end else if (buf_full && vblank && !fill_lat_q) begin
      spi_pop    = 1'b1;
      next_line  = buf_shift;
      write_line = buf_write;
      new_line   = buf_line;
    end
  end

  // Sequencer for re-alignment and level fill, plus the fill request latch.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      fill_lat_q <= 1'b0;
      fill_pat_q <= '0;
    end else begin
      // The pattern is frozen once writing has started.
      if (fill_req && state_q != FILL) begin
        fill_lat_q <= 1'b1;
        fill_pat_q <= fill_pattern;
      end
      case (state_q)
        IDLE: begin
          if (frame_pulse && head_q != '0) begin
            state_q <= ALIGN;
          end else if (vblank && fill_lat_q && head_q == '0 && !pnt_req) begin
            state_q <= FILL;
            row_q   <= '0;
          end
        end
        ALIGN: begin
          // Also exits without rotating if the painter already brought the head home.
          if (!pnt_req && head_d == '0) state_q <= IDLE;
        end
        FILL: begin
          if (fill_issue) begin
            row_q <= row_q + IDX_W'(1);
            if (row_q == LAST_ROW) begin
              state_q    <= IDLE;
              fill_lat_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Head row tracking and sticky painter-collision flag.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      head_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      head_q <= head_d;
      if (pnt_req && state_q != IDLE) conflict_q <= 1'b1;
      else if (frame_pulse)           conflict_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_state_arbiter.sv
// Self-checking bench for block_state_arbiter: directed scenarios plus
// randomized painter/SPI traffic against a reference model.
module tb_block_state_arbiter;
  import breakout_pkg::*;

  localparam int NR = 16;
  localparam int LW = LINE_W;

  logic          clk = 1'b0;
  logic          nRst;
  logic          frame_pulse, vblank;
  logic          pnt_next, pnt_write;
  logic [LW-1:0] pnt_line;
  logic          spi_valid, spi_ready, spi_write, spi_shift;
  logic [LW-1:0] spi_line;
  logic          fill_req, fill_busy;
  logic [LW-1:0] fill_pattern;
  logic          next_line, write_line;
  logic [LW-1:0] new_line;
  logic [3:0]    head_idx;
  logic          conflict;

  block_state_arbiter #(.NUM_ROWS(NR)) dut (
    .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .vblank(vblank),
    .pnt_next(pnt_next), .pnt_write(pnt_write), .pnt_line(pnt_line),
    .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_write(spi_write),
    .spi_shift(spi_shift), .spi_line(spi_line),
    .fill_req(fill_req), .fill_pattern(fill_pattern), .fill_busy(fill_busy),
    .next_line(next_line), .write_line(write_line), .new_line(new_line),
    .head_idx(head_idx), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_clear();
    frame_pulse = 1'b0; pnt_next = 1'b0; pnt_write = 1'b0; pnt_line = '0;
    spi_valid = 1'b0; spi_write = 1'b0; spi_shift = 1'b0; spi_line = '0;
    fill_req = 1'b0; fill_pattern = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_al, n_fw, n_w, last_w, order_bad, pcnt, model_head;
    logic          pn, pw, sv, sw, ss, exp_ready, exp_next, exp_write, issue;
    logic [LW-1:0] ln, sl, exp_new;
    logic          mb_full, mb_w, mb_s, was_last;
    logic [LW-1:0] mb_l;

    nRst = 1'b0; vblank = 1'b0; drive_clear();
    @(negedge clk); #1;
    chk("rst_spi_ready", spi_ready, 1);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_head", head_idx, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_outs", {next_line, write_line, new_line}, 0);
    @(negedge clk); nRst = 1'b1;
    @(negedge clk);

    // 5 painter rotates, then frame re-alignment
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_clear(); pnt_next = 1'b1; #1;
      chk("t1_pnt_pass", next_line, 1);
      @(negedge clk);
      drive_clear(); #1; @(negedge clk);
    end
    #1; chk("t1_head5", head_idx, 5);
    vblank = 1'b1; frame_pulse = 1'b1; n_al = 0;
    for (int c = 0; c < 20; c++) begin
      #1; if (next_line) n_al++;
      @(negedge clk); frame_pulse = 1'b0;
    end
    #1;
    chk("t1_align_rotates", n_al, 11);
    chk("t1_head0", head_idx, 0);

    // SPI request held through active video, issued in vblank
    @(negedge clk);
    vblank = 1'b0; drive_clear();
    spi_valid = 1'b1; spi_write = 1'b1; spi_shift = 1'b1; spi_line = 13'h1ABC; #1;
    chk("t2_ready_before", spi_ready, 1);
    @(negedge clk); drive_clear();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_ready_held", spi_ready, 0);
      chk("t2_no_issue", {next_line, write_line}, 0);
      @(negedge clk);
    end
    vblank = 1'b1; #1;
    chk("t2_issue", {write_line, next_line, new_line}, {1'b1, 1'b1, 13'h1ABC});
    @(negedge clk); #1;
    chk("t2_ready_after", spi_ready, 1);
    chk("t2_quiet_after", {next_line, write_line}, 0);
    chk("t2_head1", head_idx, 1);
    @(negedge clk);
    vblank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pnt_next = 1'b1; #1; @(negedge clk);
      pnt_next = 1'b0; #1; @(negedge clk);
    end

    // Fill request with head at 3: align first, then 16 fill writes
    fill_req = 1'b1; fill_pattern = 13'h1FFF; #1;
    chk("t3_busy_idle", fill_busy, 0);
    @(negedge clk); drive_clear(); #1;
    chk("t3_busy_latched", fill_busy, 1);
    chk("t3_head3", head_idx, 3);
    @(negedge clk);
    vblank = 1'b1; frame_pulse = 1'b1;
    n_al = 0; n_fw = 0; n_w = 0; last_w = -1; order_bad = 0; was_last = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (was_last) begin
        chk("t3_busy_drop", fill_busy, 0);
        was_last = 1'b0;
      end
      if (next_line && !write_line) begin
        n_al++;
        if (n_w != 0) order_bad = 1;
      end
      if (write_line) begin
        n_w++; last_w = c;
        if (next_line && new_line == 13'h1FFF) n_fw++;
        if (n_w == 16) begin
          chk("t3_busy_last", fill_busy, 1);
          was_last = 1'b1;
        end
      end
      @(negedge clk); frame_pulse = 1'b0;
    end
    #1;
    chk("t3_align_cnt", n_al, 13);
    chk("t3_fill_cnt", n_fw, 16);
    chk("t3_write_cnt", n_w, 16);
    chk("t3_order", order_bad, 0);
    chk("t3_last_write_cyc", last_w, 30);
    chk("t3_head0", head_idx, 0);
    chk("t3_busy_end", fill_busy, 0);

    // Painter rotates mid-fill: fill stalls, conflict flagged
    @(negedge clk);
    fill_req = 1'b1; fill_pattern = 13'h0A5A;
    n_fw = 0; last_w = -1; pcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (n_fw == 5 && pcnt < 2) begin
        pnt_next = 1'b1; pnt_line = 13'h0123; pcnt++;
      end
      #1;
      if (pnt_next) begin
        chk("t4_pnt_pass", {next_line, write_line, new_line}, {1'b1, 1'b0, 13'h0123});
      end
      if (write_line && next_line && new_line == 13'h0A5A) begin
        n_fw++; last_w = c;
      end
      @(negedge clk); drive_clear();
    end
    #1;
    chk("t4_fill_cnt", n_fw, 16);
    chk("t4_last_write_cyc", last_w, 19);
    chk("t4_conflict", conflict, 1);
    chk("t4_head2", head_idx, 2);
    chk("t4_busy_end", fill_busy, 0);
    @(negedge clk);
    frame_pulse = 1'b1; n_al = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 1) chk("t4_conflict_clr", conflict, 0);
      if (next_line) n_al++;
      @(negedge clk); frame_pulse = 1'b0;
    end
    #1;
    chk("t4_align_cnt", n_al, 14);
    chk("t4_head0", head_idx, 0);

    // Painter write collides with a buffered SPI write in vblank
    @(negedge clk);
    vblank = 1'b0; spi_valid = 1'b1; spi_write = 1'b1; spi_line = 13'h0F0F; #1;
    @(negedge clk); drive_clear();
    vblank = 1'b1; pnt_write = 1'b1; pnt_line = 13'h1234; #1;
    chk("t5_painter_wins", {write_line, next_line, new_line}, {1'b1, 1'b0, 13'h1234});
    chk("t5_ready_held", spi_ready, 0);
    @(negedge clk); drive_clear(); #1;
    chk("t5_spi_next", {write_line, next_line, new_line}, {1'b1, 1'b0, 13'h0F0F});
    @(negedge clk); #1;
    chk("t5_ready_after", spi_ready, 1);
    chk("t5_head0", head_idx, 0);
    @(negedge clk);

    // Random painter traffic during active video
    model_head = 0; vblank = 1'b0;
    for (int c = 0; c < 64; c++) begin
      drive_clear();
      pn = 1'($urandom_range(0, 1)); pw = 1'($urandom_range(0, 1)); ln = LW'($urandom);
      pnt_next = pn; pnt_write = pw; pnt_line = ln;
      #1;
      chk("r1_head", head_idx, model_head);
      chk("r1_next", next_line, pn);
      chk("r1_write", write_line, pw);
      chk("r1_new", new_line, (pn || pw) ? 32'(ln) : 32'd0);
      if (pn) model_head = (model_head + 1) % NR;
      @(negedge clk);
    end

    // Random SPI + painter traffic across vblank/active video
    mb_full = 1'b0; mb_w = 1'b0; mb_s = 1'b0; mb_l = '0;
    for (int c = 0; c < 150; c++) begin
      drive_clear();
      if (c < 144) begin
        vblank = ($urandom_range(0, 2) == 0);
        pw = ($urandom_range(0, 3) == 0);
        pn = pw ? 1'($urandom_range(0, 1)) : 1'b0;
        sv = 1'($urandom_range(0, 1));
      end else begin
        vblank = 1'b1; pw = 1'b0; pn = 1'b0; sv = 1'b0;
      end
      ln = LW'($urandom); sl = LW'($urandom);
      sw = 1'($urandom_range(0, 1)); ss = 1'($urandom_range(0, 1));
      pnt_next = pn; pnt_write = pw; pnt_line = ln;
      spi_valid = sv; spi_write = sw; spi_shift = ss; spi_line = sl;
      exp_ready = !mb_full; issue = 1'b0;
      if (pn || pw) begin
        exp_next = pn; exp_write = pw; exp_new = ln;
      end else if (mb_full && vblank) begin
        exp_next = mb_s; exp_write = mb_w; exp_new = mb_l; issue = 1'b1;
      end else begin
        exp_next = 1'b0; exp_write = 1'b0; exp_new = '0;
      end
      #1;
      chk("r2_ready", spi_ready, exp_ready);
      chk("r2_head", head_idx, model_head);
      chk("r2_next", next_line, exp_next);
      chk("r2_write", write_line, exp_write);
      chk("r2_new", new_line, exp_new);
      if (issue) mb_full = 1'b0;
      if (sv && exp_ready && (sw || ss)) begin
        mb_full = 1'b1; mb_w = sw; mb_s = ss; mb_l = sl;
      end
      if (exp_next) model_head = (model_head + 1) % NR;
      @(negedge clk);
    end

    // Reset asserted while the fill is at row 7
    drive_clear(); vblank = 1'b1; frame_pulse = 1'b1;
    fill_req = 1'b1; fill_pattern = 13'h1555; n_fw = 0;
    for (int c = 0; c < 60 && n_fw < 7; c++) begin
      #1;
      if (write_line && next_line && new_line == 13'h1555) n_fw++;
      @(negedge clk); drive_clear();
    end
    #1;
    chk("t6_reached_row7", n_fw, 7);
    chk("t6_pre_busy", fill_busy, 1);
    nRst = 1'b0; #1;
    chk("t6_rst_outs", {next_line, write_line, new_line}, 0);
    chk("t6_rst_busy", fill_busy, 0);
    chk("t6_rst_ready", spi_ready, 1);
    chk("t6_rst_head", head_idx, 0);
    chk("t6_rst_conflict", conflict, 0);
    @(negedge clk); nRst = 1'b1;
    n_w = 0;
    for (int c = 0; c < 20; c++) begin
      #1; if (write_line || next_line) n_w++;
      @(negedge clk);
    end
    #1;
    chk("t6_no_resume", n_w, 0);
    chk("t6_busy_after", fill_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
